flow_ctrl: RTL and testbench

- Parametrised program-flow controller, the successor to the fixed 8-bit core controller.
- Decodes controller-addressed instructions (device field ir[7:4]) and owns the program counter.
- Implements direct and conditional jumps, a counted wait, stop/resume, and the instruction-register enable code.
- Sits between the instruction register, the compare unit (which supplies flags) and instruction fetch.

---
 rtl/flow_ctrl_if.sv | 27 ++
 rtl/flow_ctrl.sv | 149 ++++++++++++++
 tb/tb_flow_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/flow_ctrl_if.sv
// Bundle between instruction register, compare unit, fetch and flow_ctrl.
// master = the surrounding core side, slave = flow_ctrl itself.
interface flow_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] ir;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  i_larger;
  logic                  i_smaller;
  logic                  i_equal;
  logic                  i_resume;
  logic [1:0]            o_ir_en;
  logic [ADDR_WIDTH-1:0] o_pc;
  logic                  o_stall;
  logic                  o_halted;

  modport master (
    output ir, i_data, i_larger, i_smaller, i_equal, i_resume,
    input  o_ir_en, o_pc, o_stall, o_halted
  );

  modport slave (
    input  ir, i_data, i_larger, i_smaller, i_equal, i_resume,
    output o_ir_en, o_pc, o_stall, o_halted
  );
endinterface

// File: rtl/flow_ctrl.sv
// Program-flow controller: owns the PC, decodes jumps, counted wait, stop/resume.
// Optional single-entry CALL/RET link register when FLOW_CTRL_LINK_EN is defined.
module flow_ctrl #(
  parameter int         DATA_WIDTH = 8,
  parameter int         ADDR_WIDTH = 8,
  parameter int         WAIT_WIDTH = 8,
  parameter logic [3:0] DEV_ID     = 4'hF,
  parameter logic [3:0] P_LARGER   = 4'h1,
  parameter logic [3:0] P_SMALLER  = 4'h2,
  parameter logic [3:0] P_EQUAL    = 4'h3,
  parameter logic [3:0] P_DIRECT   = 4'h4,
  parameter logic [3:0] P_WAIT     = 4'h5,
  parameter logic [3:0] P_STOP     = 4'h6
) (
  input  logic         clk,
  input  logic         rst_n,
  flow_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    S_RST  = 2'd0,
    S_WORK = 2'd1,
    S_WAIT = 2'd2,
    S_STOP = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [WAIT_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] target;
  logic [WAIT_WIDTH-1:0] wait_n;
  logic [3:0]            port;
  logic                  unused_in_bits;

`ifdef FLOW_CTRL_LINK_EN
  localparam logic [3:0] P_CALL = 4'h7;
  localparam logic [3:0] P_RET  = 4'h8;
  logic [ADDR_WIDTH-1:0] link_q, link_d;
`endif

  // Operand fields are truncated (or zero-extended) to their destination width.
  assign target         = ADDR_WIDTH'(bus.i_data);
  assign wait_n         = WAIT_WIDTH'(bus.i_data);
  assign pc_inc         = pc_q + 1'b1;
  assign port           = (bus.ir[7:4] == DEV_ID) ? bus.ir[3:0] : 4'h0;
  assign unused_in_bits = ^{bus.ir, bus.i_data};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
`ifdef FLOW_CTRL_LINK_EN
    link_d  = link_q;
`endif
    case (state_q)
      S_RST: begin
        if (port == P_DIRECT) begin
          pc_d    = target;
          state_d = S_WORK;
        end
      end
      S_WORK: begin
        if (port == P_DIRECT) begin
          pc_d = target;
        end else if (port == P_LARGER) begin
          pc_d = bus.i_larger ? target : pc_inc;
        end else if (port == P_SMALLER) begin
          pc_d = bus.i_smaller ? target : pc_inc;
        end else if (port == P_EQUAL) begin
          pc_d = bus.i_equal ? target : pc_inc;
        end else if (port == P_WAIT) begin
          if (wait_n == '0) begin
            pc_d = pc_inc;
          end else begin
            cnt_d   = wait_n;
            state_d = S_WAIT;
          end
        end else if (port == P_STOP) begin
          state_d = S_STOP;
`ifdef FLOW_CTRL_LINK_EN
        end else if (port == P_CALL) begin
          link_d = pc_inc;
          pc_d   = target;
        end else if (port == P_RET) begin
          pc_d = link_q;
`endif
        end else begin
          pc_d = pc_inc;
        end
      end
      S_WAIT: begin
        // Leaving on count==1 makes a wait of N occupy exactly N cycles.
        if (cnt_q == WAIT_WIDTH'(1)) begin
          cnt_d   = '0;
          pc_d    = pc_inc;
          state_d = S_WORK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_STOP: begin
        if (bus.i_resume) begin
          pc_d    = pc_inc;
          state_d = S_WORK;
        end
      end
      default: begin
        state_d = S_RST;
        pc_d    = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RST;
      pc_q    <= '0;
      cnt_q   <= '0;
`ifdef FLOW_CTRL_LINK_EN
      link_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
`ifdef FLOW_CTRL_LINK_EN
      link_q  <= link_d;
`endif
    end
  end

  always_comb begin
    bus.o_ir_en  = 2'b00;
    bus.o_stall  = 1'b0;
    bus.o_halted = 1'b0;
    case (state_q)
      S_RST:   bus.o_ir_en  = 2'b01;
      S_WORK:  bus.o_ir_en  = 2'b10;
      S_WAIT:  bus.o_stall  = 1'b1;
      S_STOP:  bus.o_halted = 1'b1;
      default: bus.o_ir_en  = 2'b01;
    endcase
  end

  assign bus.o_pc = pc_q;

endmodule

// File: tb/tb_flow_ctrl.sv
// Directed bench for flow_ctrl with a cycle-level reference model and literal pins.
module tb_flow_ctrl;
  localparam int DW     = 8;
  localparam int AW     = 8;
  localparam int WW     = 8;
  localparam int PC_MOD = 1 << AW;
  localparam int M_RST  = 0;
  localparam int M_WORK = 1;
  localparam int M_WAIT = 2;
  localparam int M_STOP = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  flow_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  flow_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_WIDTH(WW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  // Reference model: what the controller must be doing, in plain integers.
  int m_mode;
  int m_pc;
  int m_left;
  int m_link;

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_mode = M_RST;
    m_pc   = 0;
    m_left = 0;
    m_link = 0;
  endfunction

  function automatic int exp_ir_en();
    if (m_mode == M_RST)  return 1;
    if (m_mode == M_WORK) return 2;
    return 0;
  endfunction

  function automatic void model_step();
    int port;
    int tgt;
    int next_pc;
    port    = (bus.ir[7:4] == 4'hF) ? int'(bus.ir[3:0]) : 0;
    tgt     = int'(bus.i_data) % PC_MOD;
    next_pc = (m_pc + 1) % PC_MOD;
    if (m_mode == M_RST) begin
      if (port == 4) begin
        m_pc   = tgt;
        m_mode = M_WORK;
      end
    end else if (m_mode == M_WORK) begin
      case (port)
        4: m_pc = tgt;
        1: m_pc = bus.i_larger  ? tgt : next_pc;
        2: m_pc = bus.i_smaller ? tgt : next_pc;
        3: m_pc = bus.i_equal   ? tgt : next_pc;
        5: begin
          m_left = int'(bus.i_data) % (1 << WW);
          if (m_left == 0) m_pc = next_pc;
          else m_mode = M_WAIT;
        end
        6: m_mode = M_STOP;
`ifdef FLOW_CTRL_LINK_EN
        7: begin
          m_link = next_pc;
          m_pc   = tgt;
        end
        8: m_pc = m_link;
`endif
        default: m_pc = next_pc;
      endcase
    end else if (m_mode == M_WAIT) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_pc   = next_pc;
        m_mode = M_WORK;
      end
    end else begin
      if (bus.i_resume) begin
        m_pc   = next_pc;
        m_mode = M_WORK;
      end
    end
  endfunction

  always @(posedge clk) begin
    if (rst_n) model_step();
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_pc",     int'(bus.o_pc),     m_pc);
      chk("cyc_ir_en",  int'(bus.o_ir_en),  exp_ir_en());
      chk("cyc_stall",  int'(bus.o_stall),  int'(m_mode == M_WAIT));
      chk("cyc_halted", int'(bus.o_halted), int'(m_mode == M_STOP));
    end
  end

  task automatic apply(input logic [7:0] ir, input logic [7:0] d,
                       input logic l = 1'b0, input logic s = 1'b0,
                       input logic e = 1'b0, input logic r = 1'b0);
    @(negedge clk);
    bus.ir        = ir;
    bus.i_data    = d;
    bus.i_larger  = l;
    bus.i_smaller = s;
    bus.i_equal   = e;
    bus.i_resume  = r;
    @(posedge clk);
    #1;
  endtask

  task automatic pin(string nm, int pc, int en, int stall, int halted);
    chk({nm, "_pc"},     int'(bus.o_pc),     pc);
    chk({nm, "_ir_en"},  int'(bus.o_ir_en),  en);
    chk({nm, "_stall"},  int'(bus.o_stall),  stall);
    chk({nm, "_halted"}, int'(bus.o_halted), halted);
  endtask

  initial begin
    bus.ir = '0; bus.i_data = '0; bus.i_larger = 1'b0;
    bus.i_smaller = 1'b0; bus.i_equal = 1'b0; bus.i_resume = 1'b0;
    model_reset();
    rst_n = 1'b0;
    #12;
    pin("reset", 0, 1, 0, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // RST ignores everything but a direct jump.
    apply(8'h00, 8'h55);
    apply(8'hF1, 8'h55, 1'b1, 1'b1, 1'b1);
    pin("rst_hold", 0, 1, 0, 0);
    @(negedge clk);
    bus.ir = 8'hF4; bus.i_data = 8'h20;
    bus.i_larger = 1'b0; bus.i_smaller = 1'b0; bus.i_equal = 1'b0;
    #1;
    chk("rst_before_edge_ir_en", int'(bus.o_ir_en), 1);
    @(posedge clk); #1;
    pin("first_jump", 8'h20, 2, 0, 0);
    apply(8'h00, 8'h00);
    chk("inc1_pc", int'(bus.o_pc), 8'h21);
    apply(8'h00, 8'h00);
    chk("inc2_pc", int'(bus.o_pc), 8'h22);

    // Conditional jumps; non-matching flags must not matter.
    apply(8'hF4, 8'h10);
    apply(8'hF1, 8'h99, 1'b0, 1'b1, 1'b1);
    chk("larger_not_taken", int'(bus.o_pc), 8'h11);
    apply(8'hF3, 8'h40, 1'b0, 1'b0, 1'b1);
    chk("equal_taken", int'(bus.o_pc), 8'h40);
    apply(8'hF2, 8'h33, 1'b1, 1'b1, 1'b0);
    chk("smaller_taken", int'(bus.o_pc), 8'h33);
    apply(8'hF2, 8'h77, 1'b1, 1'b0, 1'b1);
    chk("smaller_not_taken", int'(bus.o_pc), 8'h34);
    apply(8'hF1, 8'h05, 1'b1);
    chk("larger_taken", int'(bus.o_pc), 8'h05);

    // Wait of 3 stalls exactly three cycles; ir is ignored meanwhile.
    apply(8'hF5, 8'h03);
    pin("wait_c1", 8'h05, 0, 1, 0);
    apply(8'hF4, 8'h77);
    pin("wait_c2", 8'h05, 0, 1, 0);
    apply(8'hF6, 8'h77);
    pin("wait_c3", 8'h05, 0, 1, 0);
    apply(8'hF4, 8'h77);
    pin("wait_done", 8'h06, 2, 0, 0);
    apply(8'hF5, 8'h00);
    pin("wait_zero", 8'h07, 2, 0, 0);

    // Stop holds through toggling ir until a resume pulse.
    apply(8'hF6, 8'h00);
    pin("stop", 8'h07, 0, 0, 1);
    for (int i = 0; i < 10; i++)
      apply((i % 2) ? 8'hF4 : 8'hF1, 8'h3C, 1'b1, 1'b1, 1'b1);
    pin("stop_hold", 8'h07, 0, 0, 1);
    apply(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    pin("resume", 8'h08, 2, 0, 0);
    apply(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("resume_in_work", int'(bus.o_pc), 8'h09);

    // Unknown ports and foreign devices are plain increments.
    apply(8'hF0, 8'h80);
    apply(8'hF9, 8'h80);
    apply(8'hFA, 8'h80);
    apply(8'h14, 8'h80);
    chk("noops", int'(bus.o_pc), 8'h0D);

    // PC wraps modulo 2^ADDR_WIDTH.
    apply(8'hF4, 8'hFE);
    apply(8'h00, 8'h00);
    chk("pc_ff", int'(bus.o_pc), 8'hFF);
    apply(8'h35, 8'h00);
    chk("pc_wrap", int'(bus.o_pc), 8'h00);

    apply(8'hF4, 8'h30);
`ifdef FLOW_CTRL_LINK_EN
    apply(8'hF7, 8'h50);
    chk("call", int'(bus.o_pc), 8'h50);
    apply(8'h00, 8'h00);
    apply(8'hF8, 8'h00);
    chk("ret", int'(bus.o_pc), 8'h31);
`else
    apply(8'hF7, 8'h50);
    chk("call_noop", int'(bus.o_pc), 8'h31);
    apply(8'hF8, 8'h50);
    chk("ret_noop", int'(bus.o_pc), 8'h32);
`endif

    // Asynchronous reset in the middle of a wait.
    apply(8'hF5, 8'h0A);
    apply(8'h00, 8'h00);
    pin("pre_reset_wait", int'(bus.o_pc), 0, 1, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    pin("mid_wait_reset", 0, 1, 0, 0);
    apply(8'hF4, 8'h60);
    pin("held_in_reset", 0, 1, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(8'hF4, 8'h42);
    pin("after_reset", 8'h42, 2, 0, 0);
    apply(8'h00, 8'h00);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
